four_digit_led_monitor: RTL

Receiving end of the four-digit seven-segment display interface: it watches the multiplexed anode strobes and segment bus produced by `FourDigitLEDdriver` and reconstructs the 16-bit hex word being displayed. It debounces each digit window, decodes the glyph back to a nibble and assembles a frame once all four digits have been seen. It publishes the frame with a one-cycle valid strobe and flags illegal glyphs and overlapping anodes. It is used as a self-checking monitor in display benches and as a loop-back path on board.

---
 rtl/four_digit_led_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/four_digit_led_monitor.sv
// four_digit_led_monitor: rebuilds the 16-bit hex word from a multiplexed four-digit seven-segment display
module four_digit_led_monitor #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic [6:0]  LED,
  output logic [15:0] char_out,
  output logic        char_valid,
  output logic        char_changed,
  output logic        glyph_err,
  output logic        overlap_err
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD, ST_OVERLAP} state_t;
  localparam logic [3:0] SETTLE_N = 4'(SETTLE);
  state_t      state_q, state_d;
  logic [3:0]  an_q, an_d, prev_an_q;
  logic [6:0]  led_q, led_d, prev_led_q;
  logic [3:0]  run_q, run_d;
  logic [15:0] slot_q, slot_d;
  logic [3:0]  cap_q, cap_d;
  logic        first_q, first_d;
  logic [15:0] char_out_q, char_out_d;
  logic        valid_q, valid_d;
  logic        changed_q, changed_d;
  logic        glyph_err_q, glyph_err_d;
  logic        overlap_err_q, overlap_err_d;
  logic [3:0]  low;
  logic        one_low, same, legal, sample, done;
  logic [3:0]  nib;
  logic [1:0]  idx;
  always_comb begin
    legal = 1'b1;
    nib = 4'h0;
    case (led_q)
      7'h01: nib = 4'h0;
      7'h4F: nib = 4'h1;
      7'h12: nib = 4'h2;
      7'h06: nib = 4'h3;
      7'h4C: nib = 4'h4;
      7'h24: nib = 4'h5;
      7'h20: nib = 4'h6;
      7'h0F: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h04: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h60: nib = 4'hB;
      7'h31: nib = 4'hC;
      7'h42: nib = 4'hD;
      7'h30: nib = 4'hE;
      7'h38: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    an_d = {an3, an2, an1, an0};
    led_d = LED;
    low = ~an_q;
    one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    idx = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
    same = (an_q == prev_an_q) && (led_q == prev_led_q);
    // run_d counts the cycles the registered pair has been held, including this one
    run_d = !same ? 4'd1 : (run_q == 4'hF) ? run_q : run_q + 4'd1;
    sample = one_low && !(state_q == ST_HOLD && same) && (run_d >= SETTLE_N);
    state_d = (low == 4'd0) ? ST_IDLE :
              !one_low ? ST_OVERLAP :
              sample ? ST_HOLD :
              (state_q == ST_HOLD && same) ? ST_HOLD : ST_SETTLE;
    overlap_err_d = (low != 4'd0) && !one_low && (state_q != ST_OVERLAP);
    glyph_err_d = sample && !legal;
    done = (cap_q == 4'hF);
    slot_d = slot_q;
    cap_d = done ? 4'd0 : cap_q;
    if (sample && legal) begin
      slot_d[{idx, 2'b00} +: 4] = nib;
      cap_d[idx] = 1'b1;
    end
    char_out_d = done ? slot_q : char_out_q;
    valid_d = done;
    changed_d = done && ((slot_q != char_out_q) || first_q);
    first_d = first_q && !done;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      an_q <= 4'hF;
      led_q <= 7'h7F;
      prev_an_q <= 4'hF;
      prev_led_q <= 7'h7F;
      run_q <= 4'd0;
      slot_q <= 16'h0000;
      cap_q <= 4'd0;
      first_q <= 1'b1;
      char_out_q <= 16'h0000;
      valid_q <= 1'b0;
      changed_q <= 1'b0;
      glyph_err_q <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      an_q <= an_d;
      led_q <= led_d;
      prev_an_q <= an_q;
      prev_led_q <= led_q;
      run_q <= run_d;
      slot_q <= slot_d;
      cap_q <= cap_d;
      first_q <= first_d;
      char_out_q <= char_out_d;
      valid_q <= valid_d;
      changed_q <= changed_d;
      glyph_err_q <= glyph_err_d;
      overlap_err_q <= overlap_err_d;
    end
  end
  assign char_out = char_out_q;
  assign char_valid = valid_q;
  assign char_changed = changed_q;
  assign glyph_err = glyph_err_q;
  assign overlap_err = overlap_err_q;
endmodule
